calculator_design: RTL and testbench

CALCULATOR_DESIGN -- requirements
Module: calculator_design

---
 rtl/calc_pkg.sv | 23 ++
 rtl/calc_pair_adder.sv | 20 ++
 rtl/calculator_design.sv | 59 +++++
 tb/tb_calculator_design.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared constants and operand types for the calculator pipeline
package calc_pkg;

  localparam int CALC_W = 8;

  // Field position inside the instruction word, in units of W bits
  localparam int A_IDX = 3;
  localparam int B_IDX = 2;
  localparam int C_IDX = 1;
  localparam int D_IDX = 0;

  typedef struct packed {
    logic [CALC_W-1:0] a;
    logic [CALC_W-1:0] b;
    logic [CALC_W-1:0] c;
    logic [CALC_W-1:0] d;
  } calc_instr_t;

  function automatic int field_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/calc_pair_adder.sv
// rtl/calc_pair_adder.sv - registered W+W to W+1 bit adder with synchronous active-low clear
module calc_pair_adder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W:0]   sum
);

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      sum <= '0;
    end else begin
      sum <= {1'b0, x} + {1'b0, y};
    end
  end

endmodule

// File: rtl/calculator_design.sv
// rtl/calculator_design.sv - three-stage pipelined sum of four packed unsigned operands
module calculator_design
  import calc_pkg::*;
#(
  parameter int W = CALC_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [4*W-1:0] instruction,
  output logic [W-1:0]   result
);

  localparam int A_LSB = field_lsb(A_IDX, W);
  localparam int B_LSB = field_lsb(B_IDX, W);
  localparam int C_LSB = field_lsb(C_IDX, W);
  localparam int D_LSB = field_lsb(D_IDX, W);

  if (W < 2) begin : g_bad_width
    $error("calculator_design: W must be at least 2");
  end

  logic [4*W-1:0] instr_q;
  logic [W:0]     sum_ab;
  logic [W:0]     sum_cd;

  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_q <= '0;
    end else begin
      instr_q <= instruction;
    end
  end

  calc_pair_adder #(.W(W)) u_pair_ab (
    .clk     (clk),
    .clear_n (reset),
    .x       (instr_q[A_LSB +: W]),
    .y       (instr_q[B_LSB +: W]),
    .sum     (sum_ab)
  );

  calc_pair_adder #(.W(W)) u_pair_cd (
    .clk     (clk),
    .clear_n (reset),
    .x       (instr_q[C_LSB +: W]),
    .y       (instr_q[D_LSB +: W]),
    .sum     (sum_cd)
  );

  // Carry beyond bit W-1 is dropped: the result wraps modulo 2^W
  always_ff @(posedge clk) begin
    if (!reset) begin
      result <= '0;
    end else begin
      result <= W'(sum_ab + sum_cd);
    end
  end

endmodule

// File: tb/tb_calculator_design.sv
// tb/tb_calculator_design.sv - directed table and sequence checks for calculator_design
module tb_calculator_design;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [7:0]  result;
  logic [15:0] instruction4;
  logic [3:0]  result4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  calculator_design dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .result      (result)
  );

  calculator_design #(.W(4)) dut4 (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction4),
    .result      (result4)
  );

  typedef struct {
    logic [7:0] a, b, c, d, exp;
  } vec_t;

  typedef struct {
    logic [3:0] a, b, c, d, exp;
  } vec4_t;

  vec_t       vecs[12];
  vec4_t      vecs4[3];
  logic [7:0] exp_hist[3000];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: result=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack8(input logic [7:0] a, b, c, d);
    calc_instr_t s;
    s.a = a;
    s.b = b;
    s.c = c;
    s.d = d;
    return s;
  endfunction

  initial begin
    vecs[0]  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    vecs[1]  = '{8'h02, 8'h04, 8'h06, 8'h08, 8'd20};
    vecs[2]  = '{8'h03, 8'h06, 8'h09, 8'h0C, 8'd30};
    vecs[3]  = '{8'h04, 8'h08, 8'h0C, 8'h10, 8'd40};
    vecs[4]  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC};
    vecs[5]  = '{8'h80, 8'h80, 8'h00, 8'h00, 8'h00};
    vecs[6]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[7]  = '{8'hFF, 8'h01, 8'h00, 8'h00, 8'h00};
    vecs[8]  = '{8'h7F, 8'h01, 8'h80, 8'h00, 8'h00};
    vecs[9]  = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h14};
    vecs[10] = '{8'hFF, 8'h00, 8'h00, 8'h01, 8'h00};
    vecs[11] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01};

    vecs4[0] = '{4'hF, 4'hF, 4'h1, 4'h0, 4'hF};
    vecs4[1] = '{4'h8, 4'h8, 4'h1, 4'h0, 4'h1};
    vecs4[2] = '{4'hF, 4'h1, 4'h0, 4'h0, 4'h0};

    instruction4 = 16'h0;

    // Reset held two cycles with live data, then released
    reset = 1'b0;
    instruction = pack8(8'd1, 8'd2, 8'd3, 8'd4);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("reset_hold", result, 8'h00);
    end
    reset = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("post_release", result, (i >= 3) ? 8'h0A : 8'h00);
    end

    // Back-to-back table, one instruction per cycle, 3-edge latency
    for (int i = 0; i < 14; i++) begin
      instruction = (i < 12) ? pack8(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d) : 32'h0;
      tick();
      if (i >= 2) check($sformatf("vec%0d", i - 2), result, vecs[i-2].exp);
    end

    // Reset one cycle after {10,20,30,40}: the 100 must never surface
    instruction = pack8(8'd10, 8'd20, 8'd30, 8'd40);
    tick();
    reset = 1'b0;
    tick();
    check("midreset_during", result, 8'h00);
    reset = 1'b1;
    instruction = 32'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("midreset_flush", result, 8'h00);
    end

    // Long run against a scoreboard of expected sums
    begin
      logic [7:0] a, b, c, d;
      a = 8'd200;
      b = 8'd100;
      c = 8'd50;
      d = 8'd10;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if (cyc > 0 && cyc % 50 == 0) begin
          a = a + 8'd1;
          b = b + 8'd2;
          c = c + 8'd3;
          d = d + 8'd4;
        end
        instruction = pack8(a, b, c, d);
        exp_hist[cyc] = a + b + c + d;
        tick();
        if (cyc >= 2) check($sformatf("longrun%0d", cyc - 2), result, exp_hist[cyc-2]);
      end
    end

    // Narrow instance
    instruction = 32'h0;
    for (int i = 0; i < 5; i++) begin
      instruction4 = (i < 3) ? {vecs4[i].a, vecs4[i].b, vecs4[i].c, vecs4[i].d} : 16'h0;
      tick();
      if (i >= 2) check($sformatf("w4_vec%0d", i - 2), {4'h0, result4}, {4'h0, vecs4[i-2].exp});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
